// File: rtl/max3_stream_grouper.sv
// ---------------------------------------------------------------------------
// max3_stream_grouper
//
// Purpose:
//   Collects a serial stream of unsigned samples into consecutive triples.
//   For each completed triple it presents the triple maximum, a running peak
//   over all completed triples and a completed-triple count on a valid/ready
//   output. It feeds the three-input max comparison and sits between a byte
//   source (ADC/UART) and a consumer such as a display or logger.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear of partial group, pending result,
//                   peak and count (out_max keeps its last value)
//   in_valid   in   source presents a sample
//   in_ready   out  block accepts a sample this cycle
//   in_data    in   sample value, unsigned, DATA_W bits
//   out_valid  out  result available
//   out_ready  in   consumer accepts the result
//   out_max    out  maximum of the current triple
//   out_peak   out  maximum over all completed triples since reset/clr
//   out_cnt    out  number of completed triples, CNT_W bits, wraps silently
//   out_idx    out  (only with MAX3_STREAM_INDEX_EN) winning position 1..3
//
// Configuration:
//   Define MAX3_STREAM_INDEX_EN to add the out_idx port and its logic.
//   Without it the port is absent and everything else is unchanged.
// ---------------------------------------------------------------------------
module max3_stream_grouper #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_peak,
    output logic [CNT_W-1:0]  out_cnt
`ifdef MAX3_STREAM_INDEX_EN
    ,
    output logic [1:0]        out_idx
`endif
);

    typedef enum logic [1:0] {
        ST_FILL0 = 2'd0,
        ST_FILL1 = 2'd1,
        ST_FILL2 = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] s1_q, s1_d;
    logic [DATA_W-1:0] s2_q, s2_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [DATA_W-1:0] out_peak_q, out_peak_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;

    logic              accept;
    logic              s1_wins;
    logic [DATA_W-1:0] win12;
    logic              win12_wins;
    logic [DATA_W-1:0] grp_max;

`ifdef MAX3_STREAM_INDEX_EN
    logic [1:0]        out_idx_q, out_idx_d;
    logic [1:0]        idx12;
    logic [1:0]        grp_idx;
`endif

    assign accept = in_valid && in_ready_q;

    // Two-stage strict comparison: an earlier sample only wins when it is
    // strictly larger, so ties always go to the later sample. The third
    // sample is compared straight from in_data on the edge that accepts it,
    // which is why there is no separate s3 holding register.
    assign s1_wins    = (s1_q > s2_q);
    assign win12      = s1_wins ? s1_q : s2_q;
    assign win12_wins = (win12 > in_data);
    assign grp_max    = win12_wins ? win12 : in_data;

`ifdef MAX3_STREAM_INDEX_EN
    assign idx12   = s1_wins ? 2'd1 : 2'd2;
    assign grp_idx = win12_wins ? idx12 : 2'd3;
`endif

    // Next-state and next-output computation. All outputs are registered,
    // including in_ready, which is therefore low for the first cycle after
    // reset is released and low for exactly the cycles spent in ST_OUT.
    // clr is applied last so it overrides any accept or handshake.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_max_d   = out_max_q;
        out_peak_d  = out_peak_q;
        out_cnt_d   = out_cnt_q;
`ifdef MAX3_STREAM_INDEX_EN
        out_idx_d   = out_idx_q;
`endif

        case (state_q)
            ST_FILL0: begin
                if (accept) begin
                    s1_d    = in_data;
                    state_d = ST_FILL1;
                end
            end
            ST_FILL1: begin
                if (accept) begin
                    s2_d    = in_data;
                    state_d = ST_FILL2;
                end
            end
            ST_FILL2: begin
                if (accept) begin
                    state_d     = ST_OUT;
                    out_valid_d = 1'b1;
                    out_max_d   = grp_max;
                    out_peak_d  = (grp_max > out_peak_q) ? grp_max : out_peak_q;
                    out_cnt_d   = out_cnt_q + CNT_W'(1);
`ifdef MAX3_STREAM_INDEX_EN
                    out_idx_d   = grp_idx;
`endif
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d     = ST_FILL0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_FILL0;
                out_valid_d = 1'b0;
            end
        endcase

        if (clr) begin
            state_d     = ST_FILL0;
            out_valid_d = 1'b0;
            s1_d        = '0;
            s2_d        = '0;
            out_peak_d  = '0;
            out_cnt_d   = '0;
`ifdef MAX3_STREAM_INDEX_EN
            out_idx_d   = 2'd0;
`endif
        end

        in_ready_d = (state_d != ST_OUT);
    end

    // Single state/output register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_max_q   <= '0;
            out_peak_q  <= '0;
            out_cnt_q   <= '0;
`ifdef MAX3_STREAM_INDEX_EN
            out_idx_q   <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_max_q   <= out_max_d;
            out_peak_q  <= out_peak_d;
            out_cnt_q   <= out_cnt_d;
`ifdef MAX3_STREAM_INDEX_EN
            out_idx_q   <= out_idx_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_peak  = out_peak_q;
    assign out_cnt   = out_cnt_q;
`ifdef MAX3_STREAM_INDEX_EN
    assign out_idx   = out_idx_q;
`endif

endmodule
